// File: rtl/vga_timing_pattern_gen.sv
// Parametrised video timing generator with DE/HSYNC/VSYNC and RGB test patterns.
// Optional red border on the active area is enabled by defining VGA_BORDER_EN.
module vga_timing_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   COLOR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [H_W-1:0]     H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]     V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [COLOR_W-1:0] C_MAX  = '1;

    logic [H_W-1:0]     h_cnt_q, h_cnt_d;
    logic [V_W-1:0]     v_cnt_q, v_cnt_d;
    logic               valid_q, valid_d;
    logic [1:0]         mode_q, mode_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;

    logic [31:0]        h_ext;
    logic [31:0]        v_ext;
    logic               at_origin;
    logic               active;
    logic               h_in_sync;
    logic               v_in_sync;
    logic [1:0]         mode_eff;
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    assign h_ext     = 32'(h_cnt_q);
    assign v_ext     = 32'(v_cnt_q);
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign active    = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
    assign h_in_sync = (h_ext >= 32'(H_ACTIVE + H_FP)) && (h_ext < 32'(H_ACTIVE + H_FP + H_SYNC));
    assign v_in_sync = (v_ext >= 32'(V_ACTIVE + V_FP)) && (v_ext < 32'(V_ACTIVE + V_FP + V_SYNC));

    // The first pixel of a frame already uses the mode being latched on that clock.
    assign mode_eff  = (en && at_origin) ? mode : mode_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        bar_idx = 3'd7;
        case (mode_eff)
            2'd0: begin
                // Descending scan leaves the lowest matching bar; pixels past 8 bars stay black.
                for (int i = 7; i >= 0; i--) begin
                    if (h_ext < 32'((i + 1) * BAR_W)) bar_idx = 3'(i);
                end
                pat_r = {COLOR_W{~bar_idx[1]}};
                pat_g = {COLOR_W{~bar_idx[2]}};
                pat_b = {COLOR_W{~bar_idx[0]}};
            end
            2'd1: begin
                pat_r = h_ext[COLOR_W-1:0];
                pat_g = h_ext[COLOR_W-1:0];
                pat_b = h_ext[COLOR_W-1:0];
            end
            2'd2: begin
                if (h_ext[5] ^ v_ext[5]) begin
                    pat_r = C_MAX;
                    pat_g = C_MAX;
                    pat_b = C_MAX;
                end
            end
            2'd3: begin
                pat_r = C_MAX;
                pat_g = C_MAX;
                pat_b = C_MAX;
            end
        endcase
`ifdef VGA_BORDER_EN
        if ((h_ext == 32'd0) || (h_ext == 32'(H_ACTIVE - 1)) ||
            (v_ext == 32'd0) || (v_ext == 32'(V_ACTIVE - 1))) begin
            pat_r = C_MAX;
            pat_g = '0;
            pat_b = '0;
        end
`endif
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        de_d    = 1'b0;
        hsync_d = ~HS_POL;
        vsync_d = ~VS_POL;
        fs_d    = 1'b0;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (en) begin
            if (at_origin) mode_d = mode;
            // The first enabled clock after reset only primes the pipeline at (0,0).
            valid_d = 1'b1;
            if (valid_q) begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
                de_d    = active;
                fs_d    = at_origin;
                hsync_d = h_in_sync ? HS_POL : ~HS_POL;
                vsync_d = v_in_sync ? VS_POL : ~VS_POL;
                if (active) begin
                    r_d = pat_r;
                    g_d = pat_g;
                    b_d = pat_b;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            valid_q <= 1'b0;
            mode_q  <= 2'd0;
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            fs_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule
